alu_req_arbiter: RTL and testbench
==================================

// Module: alu_req_arbiter
// PURPOSE
//  Shares one 4-bit ALU datapath between NREQ requesters.
//  Each requester issues {op,A,B} over a valid/ready handshake; a round-robin arbiter grants one per op.
//  The op executes in the shared ALU. The result is returned with requester ID and flags over a response handshake.
//  Sits between front-end sources (switch/keypad decoders, test sequencer) and the 7-seg result path.
// PARAMETERS
//  NREQ   2  number of requesters (2..4); IDW = $clog2(NREQ), min 1
//  W      4  operand/result width in bits
// PORTS
//  clk        in   1         clock, all state on rising edge
//  rst_n      in   1         asynchronous active-low reset
//  req_valid  in   NREQ      per-requester request valid
//  req_ready  out  NREQ      per-requester accept (one-hot or zero)
//  req_op     in   3*NREQ    op code, requester i at [3i+2:3i]
//  req_a      in   W*NREQ    operand A, requester i at [Wi+W-1:Wi]
//  req_b      in   W*NREQ    operand B, same packing
//  rsp_valid  out  1         response valid
//  rsp_ready  in   1         response consumer ready
//  rsp_id     out  IDW       index of requester that issued the op
//  rsp_res    out  W         result
//  rsp_flags  out  4         {carry, overflow, negative, zero}
//  busy       out  1         high in any state other than IDLE
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_res=0, rsp_flags=0, busy=0.
//  Reset is asynchronous. It aborts any in-flight op or held response with no output.
//  FSM:
//   IDLE: if any req_valid, grant the first valid index at or after rr_ptr, wrapping modulo NREQ.
//    Same cycle: req_ready[g]=1 (combinational from req_valid and rr_ptr), latch op/a/b/id, go EXEC.
//   EXEC: one cycle. Drive the latched operands through the ALU, register result and flags.
//    Set rsp_valid=1, rr_ptr=(g+1) mod NREQ, go RESP.
//   RESP: hold rsp_* stable while rsp_ready=0.
//    On rsp_valid&rsp_ready: drop rsp_valid, go IDLE.
//  Latency: request accept -> rsp_valid = 2 cycles. Throughput: one op per 3 cycles at best.
//  No new request is accepted in EXEC or RESP (req_ready=0).
//  A request is taken only when req_valid&req_ready in IDLE. Requesters hold op/a/b stable until accepted.
//  Ops (W-bit two's complement):
//   000 add A+B, carry = bit W of the sum
//   001 sub A-B computed as A+~B+1, carry = no-borrow
//   010 not ~A
//   011 and A&B
//   100 or A|B
//   101 xor A^B
//   110 signed less-than: result = {W-1 zeros, A<B}
//   111 equal: result = {W-1 zeros, A==B}
//  Flags: zero = (res==0); negative = res[W-1].
//   overflow is defined for add/sub only (signed overflow), else 0.
//   carry is defined for add/sub only, else 0.
//  Fairness: after a grant to g, g has lowest priority next arbitration. Requesters 0..NREQ-1 all valid -> grants 0,1,..,NREQ-1,0.
//  Boundaries:
//   - rsp_ready already high when entering RESP: one RESP cycle, then IDLE.
//   - req_valid dropped before grant: no grant (requester withdrew).
//   - wrap: 4'b0111+4'b0001 -> 4'b1000, overflow=1, carry=0.
//   - rr_ptr wraps from NREQ-1 to 0.
// STRUCTURE
//  Shared header alu_defs.vh:
//   - op code constants (ALU_ADD..ALU_EQ)
//   - flag bit positions
//   - FSM state encodings (IDLE=2'd0, EXEC=2'd1, RESP=2'd2)
//  One sub-module alu_core (combinational): inputs op, a, b; outputs res, flags; parameter W.
//  The arbiter FSM and round-robin logic live in alu_req_arbiter.
// TESTING
//  1. NREQ=2. Req0 valid {add,3,4}; rsp_ready=1.
//     -> req_ready[0] in the accept cycle; 2 cycles later rsp_valid, rsp_id=0, res=7, flags=0000.
//  2. Req0 and req1 both valid continuously with ops {sub,2,5} and {eq,9,9}.
//     -> responses alternate id 0,1,0,1; res 4'hD flags {1'b0,0,1,0}; then res 1, zero=0.
//  3. {add,7,1} -> res 8, overflow=1, negative=1, carry=0.
//     {add,F,1} -> res 0, carry=1, zero=1, overflow=0.
//  4. Hold rsp_ready=0 for 5 cycles with req1 pending.
//     -> rsp_* stable, req_ready=0, busy=1; req1 granted only in the cycle after the handshake completes.
//  5. Assert rst_n=0 mid-EXEC, asynchronous to clk.
//     -> all outputs 0 immediately; after release, the next grant starts at index 0.
//  6. All 8 ops with A=4'b1010, B=4'b0011.
//     -> 1101, 0111, 0101, 0010, 1011, 1001, 0001 (signed -6<3), 0000.

Source files
------------

// File: rtl/alu_req_arbiter_pkg.sv
// Shared definitions for the ALU request arbiter: op codes, flag bit positions
// and arbiter FSM state encodings.
package alu_req_arbiter_pkg;

    typedef enum logic [2:0] {
        AluAdd = 3'b000,
        AluSub = 3'b001,
        AluNot = 3'b010,
        AluAnd = 3'b011,
        AluOr  = 3'b100,
        AluXor = 3'b101,
        AluLt  = 3'b110,
        AluEq  = 3'b111
    } alu_op_e;

    localparam int unsigned NumFlags  = 4;
    localparam int unsigned FlagZero  = 0;
    localparam int unsigned FlagNeg   = 1;
    localparam int unsigned FlagOvf   = 2;
    localparam int unsigned FlagCarry = 3;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } arb_state_e;

endpackage

// File: rtl/alu_req_arbiter_alu_core.sv
// Combinational W-bit ALU: eight ops, result plus {carry, overflow, negative, zero}.
module alu_req_arbiter_alu_core
    import alu_req_arbiter_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  alu_op_e             op,
    input  logic [W-1:0]        a,
    input  logic [W-1:0]        b,
    output logic [W-1:0]        res,
    output logic [NumFlags-1:0] flags
);

    logic [W:0]   sum;
    logic [W-1:0] b_eff;
    logic         cin;
    logic         is_arith;

    always_comb begin
        is_arith = (op == AluAdd) || (op == AluSub);
        // Subtract as A + ~B + 1 so carry-out reads as no-borrow.
        b_eff    = (op == AluSub) ? ~b : b;
        cin      = (op == AluSub);
        sum      = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, cin};

        res = '0;
        case (op)
            AluAdd, AluSub: res = sum[W-1:0];
            AluNot:         res = ~a;
            AluAnd:         res = a & b;
            AluOr:          res = a | b;
            AluXor:         res = a ^ b;
            AluLt:          res = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
            AluEq:          res = {{(W-1){1'b0}}, (a == b)};
            default:        res = '0;
        endcase

        flags           = '0;
        flags[FlagZero] = (res == '0);
        flags[FlagNeg]  = res[W-1];
        if (is_arith) begin
            flags[FlagCarry] = sum[W];
            flags[FlagOvf]   = (a[W-1] == b_eff[W-1]) && (sum[W-1] != a[W-1]);
        end
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one ALU between NREQ requesters; one op in flight,
// result returned over a valid/ready response handshake.
module alu_req_arbiter
    import alu_req_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned W    = 4,
    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [3*NREQ-1:0]   req_op,
    input  logic [W*NREQ-1:0]   req_a,
    input  logic [W*NREQ-1:0]   req_b,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [W-1:0]        rsp_res,
    output logic [NumFlags-1:0] rsp_flags,
    output logic                busy
);

    arb_state_e          state_q, state_d;
    logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
    alu_op_e             op_q, op_d;
    logic [W-1:0]        a_q, a_d;
    logic [W-1:0]        b_q, b_d;
    logic [IDW-1:0]      id_q, id_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]      rsp_id_q, rsp_id_d;
    logic [W-1:0]        rsp_res_q, rsp_res_d;
    logic [NumFlags-1:0] rsp_flags_q, rsp_flags_d;

    logic                grant_found;
    logic [IDW-1:0]      grant_idx;
    logic [IDW:0]        cand_sum;
    logic [IDW-1:0]      cand;
    logic [W-1:0]        alu_res;
    logic [NumFlags-1:0] alu_flags;

    // First valid requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_sum    = '0;
        cand        = '0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            cand_sum = {1'b0, rr_ptr_q} + (IDW+1)'(off);
            if (cand_sum >= (IDW+1)'(NREQ)) begin
                cand_sum = cand_sum - (IDW+1)'(NREQ);
            end
            cand = cand_sum[IDW-1:0];
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst_n && (state_q == StIdle) && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_res_d   = rsp_res_q;
        rsp_flags_d = rsp_flags_q;
        case (state_q)
            StIdle: begin
                if (grant_found) begin
                    op_d    = alu_op_e'(req_op[3*grant_idx +: 3]);
                    a_d     = req_a[W*grant_idx +: W];
                    b_d     = req_b[W*grant_idx +: W];
                    id_d    = grant_idx;
                    state_d = StExec;
                end
            end
            StExec: begin
                rsp_res_d   = alu_res;
                rsp_flags_d = alu_flags;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                // Winner drops to lowest priority for the next arbitration.
                rr_ptr_d    = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);
                state_d     = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            op_q        <= AluAdd;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_res_q   <= '0;
            rsp_flags_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_res_q   <= rsp_res_d;
            rsp_flags_q <= rsp_flags_d;
        end
    end

    alu_req_arbiter_alu_core #(
        .W(W)
    ) u_alu (
        .op   (op_q),
        .a    (a_q),
        .b    (b_q),
        .res  (alu_res),
        .flags(alu_flags)
    );

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_res   = rsp_res_q;
    assign rsp_flags = rsp_flags_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Scoreboard bench for alu_req_arbiter with NREQ=2, W=4: expected responses are queued
// at accept time and a separate monitor compares each response handshake.
module tb_alu_req_arbiter;
    import alu_req_arbiter_pkg::*;

    localparam int unsigned NREQ = 2;
    localparam int unsigned W    = 4;
    localparam int unsigned IDW  = 1;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [3*NREQ-1:0]   req_op = '0;
    logic [W*NREQ-1:0]   req_a = '0;
    logic [W*NREQ-1:0]   req_b = '0;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [W-1:0]        rsp_res;
    logic [NumFlags-1:0] rsp_flags;
    logic                busy;

    always #5 clk = ~clk;

    alu_req_arbiter #(
        .NREQ(NREQ),
        .W   (W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op   (req_op),
        .req_a    (req_a),
        .req_b    (req_b),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id   (rsp_id),
        .rsp_res  (rsp_res),
        .rsp_flags(rsp_flags),
        .busy     (busy)
    );

    typedef struct {
        alu_op_e    op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] res;
        logic [3:0] flags;
    } stim_t;

    typedef struct {
        logic [IDW-1:0] id;
        logic [3:0]     res;
        logic [3:0]     flags;
    } exp_t;

    stim_t      sq0[$];
    stim_t      sq1[$];
    exp_t       exp_q[$];
    int         got_ids[$];
    logic [1:0] en = 2'b00;
    int         total = 0;
    int         bad = 0;

    function automatic stim_t mk(alu_op_e op, logic [3:0] a, logic [3:0] b,
                                 logic [3:0] r, logic [3:0] f);
        stim_t s;
        s.op = op; s.a = a; s.b = b; s.res = r; s.flags = f;
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Requester driver: records accepts into the scoreboard, then presents the next entry.
    always begin
        logic [1:0] acc;
        exp_t       e;
        @(negedge clk);
        acc = rst_n ? (req_valid & req_ready) : 2'b00;
        if (acc[0] && sq0.size() > 0) begin
            e.id = 1'b0; e.res = sq0[0].res; e.flags = sq0[0].flags;
            exp_q.push_back(e);
        end
        if (acc[1] && sq1.size() > 0) begin
            e.id = 1'b1; e.res = sq1[0].res; e.flags = sq1[0].flags;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (acc[0] && sq0.size() > 0) void'(sq0.pop_front());
        if (acc[1] && sq1.size() > 0) void'(sq1.pop_front());
        req_valid[0] = en[0] && (sq0.size() > 0);
        req_valid[1] = en[1] && (sq1.size() > 0);
        if (sq0.size() > 0) begin
            req_op[2:0] = sq0[0].op; req_a[3:0] = sq0[0].a; req_b[3:0] = sq0[0].b;
        end
        if (sq1.size() > 0) begin
            req_op[5:3] = sq1[0].op; req_a[7:4] = sq1[0].a; req_b[7:4] = sq1[0].b;
        end
    end

    // Response monitor.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && rsp_valid && rsp_ready) begin
            got_ids.push_back(int'(rsp_id));
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 32'(1), 32'(0));
            end else begin
                e = exp_q.pop_front();
                check("rsp_id", 32'(rsp_id), 32'(e.id));
                check("rsp_res", 32'(rsp_res), 32'(e.res));
                check("rsp_flags", 32'(rsp_flags), 32'(e.flags));
            end
        end
    end

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((sq0.size() > 0 || sq1.size() > 0 || exp_q.size() > 0 || busy) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(k < 200), 32'(1));
    endtask

    task automatic wait_ready(input int idx, input string name);
        logic found;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (req_ready[idx]) found = 1'b1;
        end
        check(name, 32'(found), 32'(1));
    endtask

    initial begin
        int   exp_ids[4];
        logic found;
        exp_ids = '{1, 0, 1, 0};
        rst_n     = 1'b0;
        rsp_ready = 1'b0;
        #2;
        check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("rst_rsp_id", 32'(rsp_id), 32'(0));
        check("rst_rsp_res", 32'(rsp_res), 32'(0));
        check("rst_rsp_flags", 32'(rsp_flags), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_req_ready", 32'(req_ready), 32'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single add: accept, one EXEC cycle, then response.
        rsp_ready = 1'b1;
        sq0.push_back(mk(AluAdd, 4'd3, 4'd4, 4'd7, 4'b0000));
        en = 2'b01;
        wait_ready(0, "t1_accept");
        check("t1_ready_onehot", 32'(req_ready), 32'(2'b01));
        check("t1_busy_accept", 32'(busy), 32'(0));
        @(negedge clk);
        check("t1_exec_valid", 32'(rsp_valid), 32'(0));
        check("t1_exec_busy", 32'(busy), 32'(1));
        @(negedge clk);
        check("t1_lat_valid", 32'(rsp_valid), 32'(1));
        drain("t1_drain");

        // Both requesters continuously valid; pointer is 1 after the req0 grant.
        got_ids.delete();
        sq0.push_back(mk(AluSub, 4'd2, 4'd5, 4'hD, 4'b0010));
        sq0.push_back(mk(AluSub, 4'd2, 4'd5, 4'hD, 4'b0010));
        sq1.push_back(mk(AluEq, 4'd9, 4'd9, 4'd1, 4'b0000));
        sq1.push_back(mk(AluEq, 4'd9, 4'd9, 4'd1, 4'b0000));
        en = 2'b11;
        drain("t2_drain");
        check("t2_count", 32'(got_ids.size()), 32'(4));
        for (int i = 0; i < 4 && i < got_ids.size(); i++) begin
            check($sformatf("t2_order%0d", i), 32'(got_ids[i]), 32'(exp_ids[i]));
        end

        // Add wrap cases from requester 1, leaving the pointer at 0.
        sq1.push_back(mk(AluAdd, 4'h7, 4'h1, 4'h8, 4'b0110));
        sq1.push_back(mk(AluAdd, 4'hF, 4'h1, 4'h0, 4'b1001));
        en = 2'b10;
        drain("t3_drain");

        // Backpressure with req1 pending.
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        sq0.push_back(mk(AluAnd, 4'hC, 4'hA, 4'h8, 4'b0010));
        sq1.push_back(mk(AluOr, 4'h1, 4'h2, 4'h3, 4'b0000));
        en = 2'b11;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (rsp_valid) found = 1'b1;
        end
        check("t4_rsp_seen", 32'(found), 32'(1));
        for (int c = 0; c < 5; c++) begin
            check("t4_hold_valid", 32'(rsp_valid), 32'(1));
            check("t4_hold_res", 32'(rsp_res), 32'(4'h8));
            check("t4_hold_id", 32'(rsp_id), 32'(0));
            check("t4_hold_flags", 32'(rsp_flags), 32'(4'b0010));
            check("t4_hold_ready", 32'(req_ready), 32'(0));
            check("t4_hold_busy", 32'(busy), 32'(1));
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("t4_hs_ready", 32'(req_ready), 32'(2'b00));
        @(negedge clk);
        check("t4_req1_grant", 32'(req_ready), 32'(2'b10));
        drain("t4_drain");

        // All eight ops with A=1010, B=0011 from requester 0.
        sq0.push_back(mk(AluAdd, 4'hA, 4'h3, 4'b1101, 4'b0010));
        sq0.push_back(mk(AluSub, 4'hA, 4'h3, 4'b0111, 4'b1100));
        sq0.push_back(mk(AluNot, 4'hA, 4'h3, 4'b0101, 4'b0000));
        sq0.push_back(mk(AluAnd, 4'hA, 4'h3, 4'b0010, 4'b0000));
        sq0.push_back(mk(AluOr,  4'hA, 4'h3, 4'b1011, 4'b0010));
        sq0.push_back(mk(AluXor, 4'hA, 4'h3, 4'b1001, 4'b0010));
        sq0.push_back(mk(AluLt,  4'hA, 4'h3, 4'b0001, 4'b0000));
        sq0.push_back(mk(AluEq,  4'hA, 4'h3, 4'b0000, 4'b0001));
        en = 2'b01;
        drain("t6_drain");

        // Asynchronous reset mid-EXEC; pointer is 1 beforehand.
        sq1.push_back(mk(AluXor, 4'hF, 4'h0, 4'hF, 4'b0010));
        en = 2'b10;
        wait_ready(1, "t5_accept");
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        en = 2'b00;
        exp_q.delete();
        sq0.delete();
        sq1.delete();
        check("t5_rst_valid", 32'(rsp_valid), 32'(0));
        check("t5_rst_busy", 32'(busy), 32'(0));
        check("t5_rst_ready", 32'(req_ready), 32'(0));
        check("t5_rst_res", 32'(rsp_res), 32'(0));
        check("t5_rst_flags", 32'(rsp_flags), 32'(0));
        check("t5_rst_id", 32'(rsp_id), 32'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        got_ids.delete();
        sq0.push_back(mk(AluAdd, 4'd1, 4'd1, 4'd2, 4'b0000));
        sq1.push_back(mk(AluAdd, 4'd2, 4'd2, 4'd4, 4'b0000));
        en = 2'b11;
        drain("t5_drain");
        check("t5_count", 32'(got_ids.size()), 32'(2));
        if (got_ids.size() >= 2) begin
            check("t5_first_id", 32'(got_ids[0]), 32'(0));
            check("t5_second_id", 32'(got_ids[1]), 32'(1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
